// File: rtl/solver_pkg.sv
// Shared encodings and constants for the solver dispatch slice.
package solver_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CFG     = 3'd1;
    localparam logic [2:0] ST_LOAD_RE = 3'd2;
    localparam logic [2:0] ST_LOAD_IM = 3'd3;
    localparam logic [2:0] ST_START   = 3'd4;

    localparam logic [15:0] ITER_LIMIT_HIT = 16'hFFFF;
    localparam logic [1:0]  GUARD_CYCLES   = 2'd2;

endpackage

// File: rtl/solver_dispatch_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  logic [3:0]   ptr,
    output logic [N-1:0] grant,
    output logic         valid
);

    int unsigned idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/solver_dispatch.sv
// Loads pixel jobs into idle solvers and returns their iteration counts round-robin.
module solver_dispatch
    import solver_pkg::*;
#(
    parameter int unsigned NUM_SOLVERS     = 4,
    parameter int unsigned LIMB_INDEX_BITS = 6,
    parameter int unsigned LIMB_BITS       = 32,
    parameter int unsigned ID_BITS         = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
    input  logic [15:0]                cfg_iter_lim,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [ID_BITS-1:0]         job_id,
    input  logic                       limb_valid,
    output logic                       limb_ready,
    input  logic [LIMB_BITS-1:0]       limb_data,
    output logic [NUM_SOLVERS-1:0]     sol_wr_real_en,
    output logic [NUM_SOLVERS-1:0]     sol_wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0] sol_wr_ind,
    output logic [LIMB_BITS-1:0]       sol_limb_data,
    output logic                       sol_wr_num_limbs_en,
    output logic                       sol_wr_iter_lim_en,
    output logic [LIMB_INDEX_BITS-1:0] sol_num_limbs,
    output logic [15:0]                sol_iter_lim,
    output logic [NUM_SOLVERS-1:0]     sol_start,
    input  logic [NUM_SOLVERS-1:0]     sol_out_ready,
    input  logic [16*NUM_SOLVERS-1:0]  sol_iteration_count,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_BITS-1:0]         res_id,
    output logic [15:0]                res_iter,
    output logic [3:0]                 res_solver,
    output logic                       idle
);

    logic [2:0]                 state;
    logic [NUM_SOLVERS-1:0]     busy, pending, free_mask, tgt_onehot, capture, hs_mask;
    logic [NUM_SOLVERS-1:0]     arb_req, grant;
    logic [1:0]                 guard [NUM_SOLVERS];
    logic [ID_BITS-1:0]         tag   [NUM_SOLVERS];
    logic [15:0]                count [NUM_SOLVERS];
    logic [3:0]                 target, lowest_free, rr_ptr, ptr_eff, nxt_solver;
    logic [ID_BITS-1:0]         job_id_q, nxt_id;
    logic [LIMB_INDEX_BITS-1:0] limb_cnt, num_limbs_q;
    logic [15:0]                iter_lim_q, nxt_iter;
    logic                       cfg_fire, job_fire, limb_fire, last_limb, res_hs, grant_valid;

    assign free_mask  = ~busy & ~pending;
    assign cfg_ready  = (state == ST_IDLE) && (busy == '0) && (pending == '0);
    assign idle       = cfg_ready;
    assign cfg_fire   = cfg_valid && cfg_ready;
    assign job_ready  = (state == ST_IDLE) && !cfg_fire && (|free_mask);
    assign job_fire   = job_valid && job_ready;
    assign limb_ready = (state == ST_LOAD_RE) || (state == ST_LOAD_IM);
    assign limb_fire  = limb_valid && limb_ready;
    assign last_limb  = (limb_cnt == num_limbs_q - LIMB_INDEX_BITS'(1));
    assign res_hs     = res_valid && res_ready;

    assign sol_wr_real_en      = (state == ST_LOAD_RE && limb_valid) ? tgt_onehot : '0;
    assign sol_wr_imag_en      = (state == ST_LOAD_IM && limb_valid) ? tgt_onehot : '0;
    assign sol_wr_ind          = limb_cnt;
    assign sol_limb_data       = limb_data;
    assign sol_wr_num_limbs_en = (state == ST_CFG);
    assign sol_wr_iter_lim_en  = (state == ST_CFG);
    assign sol_num_limbs       = num_limbs_q;
    assign sol_iter_lim        = iter_lim_q;
    assign sol_start           = (state == ST_START) ? tgt_onehot : '0;

    always_comb begin
        lowest_free = '0;
        for (int unsigned i = NUM_SOLVERS; i > 0; i--)
            if (free_mask[i-1]) lowest_free = 4'(i - 1);
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
            tgt_onehot[i] = (target == 4'(i));
            hs_mask[i]    = res_hs && (res_solver == 4'(i));
            capture[i]    = busy[i] && (guard[i] == '0) && sol_out_ready[i];
        end
    end

    // The result being handed over this cycle is excluded so the next one can follow immediately.
    assign arb_req = pending & ~hs_mask;
    assign ptr_eff = !res_hs ? rr_ptr :
                     (res_solver == 4'(NUM_SOLVERS - 1)) ? 4'd0 : res_solver + 4'd1;

    rr_arbiter #(.N(NUM_SOLVERS)) u_rr_arbiter (
        .req   (arb_req),
        .ptr   (ptr_eff),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        nxt_id     = '0;
        nxt_iter   = '0;
        nxt_solver = '0;
        for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
            if (grant[i]) begin
                nxt_id     = tag[i];
                nxt_iter   = count[i];
                nxt_solver = 4'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= '0;
            pending     <= '0;
            target      <= '0;
            job_id_q    <= '0;
            limb_cnt    <= '0;
            num_limbs_q <= LIMB_INDEX_BITS'(1);
            iter_lim_q  <= '0;
            rr_ptr      <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_iter    <= '0;
            res_solver  <= '0;
            for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
                guard[i] <= '0;
                tag[i]   <= '0;
                count[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        num_limbs_q <= (cfg_num_limbs == '0) ? LIMB_INDEX_BITS'(1) : cfg_num_limbs;
                        iter_lim_q  <= cfg_iter_lim;
                        state       <= ST_CFG;
                    end else if (job_fire) begin
                        job_id_q <= job_id;
                        target   <= lowest_free;
                        limb_cnt <= '0;
                        state    <= ST_LOAD_RE;
                    end
                end
                ST_CFG: state <= ST_IDLE;
                ST_LOAD_RE, ST_LOAD_IM: begin
                    if (limb_fire) begin
                        if (last_limb) begin
                            limb_cnt <= '0;
                            state    <= (state == ST_LOAD_RE) ? ST_LOAD_IM : ST_START;
                        end else begin
                            limb_cnt <= limb_cnt + LIMB_INDEX_BITS'(1);
                        end
                    end
                end
                ST_START: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

            for (int unsigned i = 0; i < NUM_SOLVERS; i++) begin
                if (guard[i] != '0) guard[i] <= guard[i] - 2'd1;
                if (capture[i]) begin
                    busy[i]    <= 1'b0;
                    pending[i] <= 1'b1;
                    count[i]   <= sol_iteration_count[16*i +: 16];
                end
                if (hs_mask[i]) pending[i] <= 1'b0;
                if (state == ST_START && tgt_onehot[i]) begin
                    busy[i]  <= 1'b1;
                    guard[i] <= GUARD_CYCLES;
                    tag[i]   <= job_id_q;
                end
            end

            if (res_hs) rr_ptr <= ptr_eff;
            if (!res_valid || res_hs) begin
                res_valid <= grant_valid;
                if (grant_valid) begin
                    res_id     <= nxt_id;
                    res_iter   <= nxt_iter;
                    res_solver <= nxt_solver;
                end
            end
        end
    end

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed + randomized bench for solver_dispatch with a behavioural job/result model.
module tb_solver_dispatch;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0, cfg_ready;
    logic [5:0]    cfg_num_limbs = '0;
    logic [15:0]   cfg_iter_lim = '0;
    logic          job_valid = 1'b0, job_ready;
    logic [15:0]   job_id = '0;
    logic          limb_valid = 1'b0, limb_ready;
    logic [31:0]   limb_data = '0;
    logic [N-1:0]  sol_wr_real_en, sol_wr_imag_en, sol_start;
    logic [5:0]    sol_wr_ind, sol_num_limbs;
    logic [31:0]   sol_limb_data;
    logic          sol_wr_num_limbs_en, sol_wr_iter_lim_en;
    logic [15:0]   sol_iter_lim;
    logic [N-1:0]  sol_out_ready = '0;
    logic [16*N-1:0] sol_iteration_count = '0;
    logic          res_valid, res_ready = 1'b0, idle;
    logic [15:0]   res_id, res_iter;
    logic [3:0]    res_solver;

    solver_dispatch #(
        .NUM_SOLVERS(N), .LIMB_INDEX_BITS(6), .LIMB_BITS(32), .ID_BITS(16)
    ) dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim),
        .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
        .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_data(limb_data),
        .sol_wr_real_en(sol_wr_real_en), .sol_wr_imag_en(sol_wr_imag_en),
        .sol_wr_ind(sol_wr_ind), .sol_limb_data(sol_limb_data),
        .sol_wr_num_limbs_en(sol_wr_num_limbs_en), .sol_wr_iter_lim_en(sol_wr_iter_lim_en),
        .sol_num_limbs(sol_num_limbs), .sol_iter_lim(sol_iter_lim),
        .sol_start(sol_start), .sol_out_ready(sol_out_ready),
        .sol_iteration_count(sol_iteration_count),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_iter(res_iter), .res_solver(res_solver), .idle(idle)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: which solvers hold a running job or an unconsumed result, plus the fairness pointer.
    bit          m_busy [N];
    bit          m_pend [N];
    logic [15:0] m_id   [N];
    logic [15:0] m_cnt  [N];
    int          m_ptr;
    int          m_n;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_pend[i] = 0;
            m_id[i]   = '0;
            m_cnt[i]  = '0;
        end
        m_ptr = 0;
        m_n   = 1;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < N; i++)
            if (!m_busy[i] && !m_pend[i]) return i;
        return -1;
    endfunction

    function automatic int next_winner();
        for (int k = 0; k < N; k++)
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int s);
        logic [N-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic cfg_check(input logic [15:0] lim);
        check("cfg_wr_num_limbs_en", sol_wr_num_limbs_en, 1);
        check("cfg_wr_iter_lim_en", sol_wr_iter_lim_en, 1);
        check("cfg_num_limbs", sol_num_limbs, m_n);
        check("cfg_iter_lim", sol_iter_lim, lim);
        tick();
        check("cfg_pulse_end", {sol_wr_num_limbs_en, sol_wr_iter_lim_en}, 0);
    endtask

    task automatic do_cfg(input int n, input logic [15:0] lim);
        cfg_num_limbs = 6'(n);
        cfg_iter_lim  = lim;
        cfg_valid     = 1'b1;
        #1;
        check("cfg_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        m_n = (n == 0) ? 1 : n;
        cfg_check(lim);
    endtask

    task automatic load_job(input logic [15:0] id, input bit stalls);
        int s;
        s = lowest_free();
        job_id    = id;
        job_valid = 1'b1;
        #1;
        check("job_ready", job_ready, 1);
        tick();
        job_valid = 1'b0;
        for (int j = 0; j < 2 * m_n; j++) begin
            if (stalls && $urandom_range(0, 1) == 1) begin
                limb_valid = 1'b0;
                #1;
                check("stall_no_write", {sol_wr_real_en, sol_wr_imag_en}, 0);
                tick();
            end
            limb_valid = 1'b1;
            limb_data  = $urandom;
            #1;
            check("limb_ready", limb_ready, 1);
            check("wr_real_en", sol_wr_real_en, (j < m_n) ? onehot(s) : '0);
            check("wr_imag_en", sol_wr_imag_en, (j < m_n) ? '0 : onehot(s));
            check("wr_ind", sol_wr_ind, j % m_n);
            check("wr_data", sol_limb_data, limb_data);
            tick();
        end
        limb_valid = 1'b0;
        check("start", sol_start, onehot(s));
        m_busy[s] = 1;
        m_id[s]   = id;
        tick();
        check("start_one_cycle", sol_start, 0);
        // The emulated solver keeps its previous done level one cycle past start.
        tick();
        sol_out_ready[s] = 1'b0;
    endtask

    task automatic complete(input int s, input logic [15:0] cnt);
        sol_iteration_count[16*s +: 16] = cnt;
        sol_out_ready[s] = 1'b1;
        m_busy[s] = 0;
        m_pend[s] = 1;
        m_cnt[s]  = cnt;
    endtask

    task automatic drain_one(input int stall);
        int w;
        int e;
        w = 0;
        e = next_winner();
        while (!res_valid && w < 20) begin
            tick();
            w++;
        end
        check("res_valid", res_valid, 1);
        if (!res_valid || e < 0) return;
        check("res_id", res_id, m_id[e]);
        check("res_iter", res_iter, m_cnt[e]);
        check("res_solver", res_solver, e);
        for (int k = 0; k < stall; k++) begin
            tick();
            check("hold_valid", res_valid, 1);
            check("hold_id", res_id, m_id[e]);
            check("hold_iter", res_iter, m_cnt[e]);
            check("hold_solver", res_solver, e);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        m_pend[e] = 0;
        m_ptr = (e + 1) % N;
    endtask

    initial begin
        logic [15:0] lim;
        int k;

        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        check("rst_idle", idle, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_start", sol_start, 0);
        check("rst_wr_en", {sol_wr_real_en, sol_wr_imag_en, sol_wr_num_limbs_en, sol_wr_iter_lim_en}, 0);
        check("rst_num_limbs", sol_num_limbs, 1);
        check("rst_iter_lim", sol_iter_lim, 0);
        check("rst_limb_ready", limb_ready, 0);
        check("rst_cfg_ready", cfg_ready, 1);

        // Single job through solver 0, result 42.
        do_cfg(2, 16'd100);
        load_job(16'd7, 1'b0);
        complete(0, 16'd42);
        drain_one(0);
        check("idle_after_first", idle, 1);

        // Fill all solvers; solver 0 still shows its old done level during start.
        for (int i = 0; i < N; i++) load_job(16'($urandom), 1'b1);
        job_id    = 16'($urandom);
        job_valid = 1'b1;
        #1;
        check("job_ready_all_busy", job_ready, 0);
        job_valid = 1'b0;
        repeat (3) tick();
        check("no_stale_result", res_valid, 0);
        check("not_idle_busy", idle, 0);

        // Solvers 1 and 3 finish together; host stalls 3 cycles.
        complete(1, 16'($urandom));
        complete(3, 16'($urandom));
        drain_one(3);
        check("back_to_back_valid", res_valid, 1);
        check("back_to_back_solver", res_solver, 3);
        drain_one(0);

        // Config request waits for solvers 0 and 2; pointer now starts at 0.
        lim = 16'($urandom);
        cfg_num_limbs = 6'd0;
        cfg_iter_lim  = lim;
        cfg_valid     = 1'b1;
        #1;
        check("cfg_blocked_busy", cfg_ready, 0);
        tick();
        check("cfg_blocked_busy2", cfg_ready, 0);
        complete(2, 16'($urandom));
        complete(0, 16'hFFFF);
        drain_one(1);
        check("cfg_blocked_pending", cfg_ready, 0);
        drain_one(0);
        check("cfg_ready_after_drain", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        m_n = 1;
        cfg_check(lim);

        // Reset in the middle of the imaginary limb phase.
        job_id    = 16'($urandom);
        job_valid = 1'b1;
        tick();
        job_valid  = 1'b0;
        limb_valid = 1'b1;
        limb_data  = $urandom;
        tick();
        check("imag_before_reset", sol_wr_imag_en, onehot(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check("mid_rst_wr_en", {sol_wr_real_en, sol_wr_imag_en}, 0);
        check("mid_rst_limb_ready", limb_ready, 0);
        check("mid_rst_start", sol_start, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_num_limbs", sol_num_limbs, 1);
        limb_valid = 1'b0;
        repeat (3) tick();
        check("mid_rst_idle_stays", idle, 1);

        // Randomized rounds against the model.
        do_cfg($urandom_range(1, 3), 16'($urandom));
        for (int r = 0; r < 6; r++) begin
            k = $urandom_range(1, N);
            for (int i = 0; i < k; i++) load_job(16'($urandom), 1'b1);
            repeat (3) tick();
            for (int i = 0; i < k; i++)
                complete(i, ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
            for (int i = 0; i < k; i++) drain_one($urandom_range(0, 2));
            check("round_idle", idle, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
